// File: rtl/key_pio_pkg.sv
// Shared register map and edge-select encoding for the key PIO.
package key_pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_ESEL = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAPT = 3'd3;
  localparam logic [2:0] ADDR_DBTH = 3'd4;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

endpackage

// File: rtl/key_pio_chan.sv
// One input channel: synchroniser chain, optional debounce counter, stable level and update events.
// Debounce counter exists only when KEY_PIO_DEBOUNCE_EN is defined; otherwise the stable level follows in one cycle.
module key_pio_chan #(
  parameter int   SYNC_STAGES = 2,
`ifdef KEY_PIO_DEBOUNCE_EN
  parameter int   DB_CNT_W    = 16,
`endif
  parameter logic IDLE        = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
`ifdef KEY_PIO_DEBOUNCE_EN
  input  logic [DB_CNT_W-1:0] thresh,
`endif
  input  logic                din,
  output logic                stable,
  output logic                rise_evt,
  output logic                fall_evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic                   synced;
  logic                   update;

`ifdef KEY_PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0]    cnt_q, cnt_d;

  // A programmed threshold of zero behaves like one.
  function automatic logic [DB_CNT_W-1:0] eff_thresh(input logic [DB_CNT_W-1:0] t);
    return (t == '0) ? DB_CNT_W'(1) : t;
  endfunction
`endif

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    stable_d = stable_q;
    update   = 1'b0;
`ifdef KEY_PIO_DEBOUNCE_EN
    cnt_d    = '0;
    if (synced != stable_q) begin
      // cnt holds the mismatches already seen; this cycle is one more.
      if (({1'b0, cnt_q} + {{DB_CNT_W{1'b0}}, 1'b1}) >= {1'b0, eff_thresh(thresh)}) begin
        update = 1'b1;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
`else
    update   = (synced != stable_q);
`endif
    if (update) begin
      stable_d = synced;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{IDLE}};
      stable_q <= IDLE;
`ifdef KEY_PIO_DEBOUNCE_EN
      cnt_q    <= '0;
`endif
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
`ifdef KEY_PIO_DEBOUNCE_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign stable   = stable_q;
  assign rise_evt = update & synced;
  assign fall_evt = update & ~synced;

endmodule

// File: rtl/key_pio_debounced.sv
// Avalon-MM input PIO: per-bit sync/debounce channels, edge capture with W1C, masked level irq.
// Optional debounce filter and threshold register at address 4 enabled by KEY_PIO_DEBOUNCE_EN.
module key_pio_debounced
  import key_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_LEVEL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] EDGE_RESET  = {WIDTH{1'b0}},
  parameter int               DB_CNT_W    = 16,
  parameter int               DB_RESET    = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_w, rise_w, fall_w;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] cap_set, cap_clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

`ifdef KEY_PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] thresh_q, thresh_d;
`else
  localparam int unused_db_cfg = DB_CNT_W + DB_RESET;
`endif

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    key_pio_chan #(
      .SYNC_STAGES(SYNC_STAGES),
`ifdef KEY_PIO_DEBOUNCE_EN
      .DB_CNT_W   (DB_CNT_W),
`endif
      .IDLE       (IDLE_LEVEL[g])
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
`ifdef KEY_PIO_DEBOUNCE_EN
      .thresh  (thresh_q),
`endif
      .din     (in_port[g]),
      .stable  (stable_w[g]),
      .rise_evt(rise_w[g]),
      .fall_evt(fall_w[g])
    );
  end

  always_comb begin
    edge_sel_d = edge_sel_q;
    irq_mask_d = irq_mask_q;
    cap_clr    = '0;
    cap_set    = '0;
`ifdef KEY_PIO_DEBOUNCE_EN
    thresh_d   = thresh_q;
`endif
    if (wr_en) begin
      case (address)
        ADDR_ESEL: edge_sel_d = writedata[WIDTH-1:0];
        ADDR_MASK: irq_mask_d = writedata[WIDTH-1:0];
        ADDR_CAPT: cap_clr    = writedata[WIDTH-1:0];
`ifdef KEY_PIO_DEBOUNCE_EN
        ADDR_DBTH: thresh_d   = writedata[DB_CNT_W-1:0];
`endif
        default: ;
      endcase
    end
    for (int i = 0; i < WIDTH; i++) begin
      cap_set[i] = (edge_sel_q[i] == EDGE_RISE) ? rise_w[i] : fall_w[i];
    end
    // Set is applied after clear so an event coinciding with its W1C survives.
    edge_cap_d = (edge_cap_q & ~cap_clr) | cap_set;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0]    = stable_w;
      ADDR_ESEL: readdata_d[WIDTH-1:0]    = edge_sel_q;
      ADDR_MASK: readdata_d[WIDTH-1:0]    = irq_mask_q;
      ADDR_CAPT: readdata_d[WIDTH-1:0]    = edge_cap_q;
`ifdef KEY_PIO_DEBOUNCE_EN
      ADDR_DBTH: readdata_d[DB_CNT_W-1:0] = thresh_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_sel_q <= EDGE_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
`ifdef KEY_PIO_DEBOUNCE_EN
      thresh_q   <= DB_CNT_W'(DB_RESET);
`endif
    end else begin
      edge_sel_q <= edge_sel_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
`ifdef KEY_PIO_DEBOUNCE_EN
      thresh_q   <= thresh_d;
`endif
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
